// File: rtl/mandel_pixel_walker.sv
// mandel_pixel_walker: walks a frame (or a column-interleaved slice of it) and
// issues one signed 4.23 coordinate plus pixel (x, y) per valid/ready transfer.
module mandel_pixel_walker #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned OFFSET   = 0,
  localparam int unsigned CW      = 27,
  localparam int unsigned XW      = $clog2(H_PIXELS),
  localparam int unsigned YW      = $clog2(V_PIXELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] x_min,
  input  logic [CW-1:0] y_max,
  input  logic [CW-1:0] dx,
  input  logic [CW-1:0] dy,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [CW-1:0] out_c_r,
  output logic [CW-1:0] out_c_i,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cr_q, cr_d;
  logic [CW-1:0] ci_q, ci_d;
  logic [CW-1:0] row_cr_q, row_cr_d;   // c_r of the first column of every row
  logic [CW-1:0] step_q, step_d;       // STRIDE*dx, c_r increment per issued column
  logic [CW-1:0] dy_q, dy_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          val_q, val_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          xfer_c;
  logic          row_more_c;
  logic          last_row_c;

  assign xfer_c     = val_q & out_rdy;
  assign row_more_c = (32'(x_q) + STRIDE) < H_PIXELS;
  assign last_row_c = (y_q == YW'(V_PIXELS - 1));

  // Next-state: capture viewport on start, advance on each transfer, abort overrides.
  always_comb begin
    state_d  = state_q;
    cr_d     = cr_q;
    ci_d     = ci_q;
    row_cr_d = row_cr_q;
    step_d   = step_q;
    dy_d     = dy_q;
    x_d      = x_q;
    y_d      = y_q;
    val_d    = val_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          row_cr_d = x_min + CW'(OFFSET) * dx;
          step_d   = CW'(STRIDE) * dx;
          dy_d     = dy;
          cr_d     = x_min + CW'(OFFSET) * dx;
          ci_d     = y_max;
          x_d      = XW'(OFFSET);
          y_d      = '0;
          val_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer_c) begin
          if (row_more_c) begin
            x_d  = x_q + XW'(STRIDE);
            cr_d = cr_q + step_q;
          end else if (last_row_c) begin
            val_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            x_d  = XW'(OFFSET);
            y_d  = y_q + YW'(1);
            cr_d = row_cr_q;
            ci_d = ci_q - dy_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      val_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cr_q     <= '0;
      ci_q     <= '0;
      row_cr_q <= '0;
      step_q   <= '0;
      dy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cr_q     <= cr_d;
      ci_q     <= ci_d;
      row_cr_q <= row_cr_d;
      step_q   <= step_d;
      dy_q     <= dy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out_val    = val_q;
  assign out_c_r    = cr_q;
  assign out_c_i    = ci_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
